// File: rtl/bj_video_pkg.sv
// Shared video package: sprite-reader FSM states and default sprite-table geometry.
package bj_video_pkg;

    // Default sprite-table geometry shared with the per-line renderer
    localparam int ADDR_WIDTH_DEF      = 11;
    localparam int DATA_WIDTH_DEF      = 8;
    localparam int BYTES_PER_ENTRY_DEF = 4;
    localparam int NUM_ENTRIES_DEF     = 24;
    localparam int INDEX_WIDTH         = 5;

    // Sprite attribute reader FSM states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        DRAIN   = 3'd2,
        PRESENT = 3'd3,
        FIN     = 3'd4
    } state_e;

endpackage

// File: rtl/sprite_attr_reader.sv
// Sprite attribute reader: walks a sprite table through a 1-cycle-latency RAM
// read port, assembles each multi-byte entry and hands it downstream.
// Optional feature macro SPRITE_SKIP_EMPTY_EN: entries whose byte 0 is zero
// are dropped after capture and never presented.
//
// Output handshake: an entry transfers on a rising edge where out_valid and
// out_ready are both high. Once out_valid rises, out_data and out_index hold
// until that transfer; out_valid never drops without a transfer (except reset).
module sprite_attr_reader
    import bj_video_pkg::*;
#(
    parameter int addr_width_g      = ADDR_WIDTH_DEF,
    parameter int data_width_g      = DATA_WIDTH_DEF,
    parameter int bytes_per_entry_g = BYTES_PER_ENTRY_DEF,
    parameter int num_entries_g     = NUM_ENTRIES_DEF
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      start,
    input  logic [addr_width_g-1:0]                   base_addr,
    output logic                                      ram_enable,
    output logic [addr_width_g-1:0]                   ram_addr,
    input  logic [data_width_g-1:0]                   ram_q,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [bytes_per_entry_g*data_width_g-1:0] out_data,
    output logic [INDEX_WIDTH-1:0]                    out_index,
    output logic                                      busy,
    output logic                                      done,
    output logic [2:0]                                state_dbg
);

    localparam int LANE_W = $clog2(bytes_per_entry_g);
    localparam logic [LANE_W-1:0]      LAST_LANE  = LANE_W'(bytes_per_entry_g - 1);
    localparam logic [INDEX_WIDTH-1:0] LAST_ENTRY = INDEX_WIDTH'(num_entries_g - 1);

    state_e                                    state_q;
    logic                                      ram_enable_q;
    logic [addr_width_g-1:0]                   ram_addr_q;
    logic [LANE_W-1:0]                         lane_q;
    logic                                      cap_valid_q;
    logic [LANE_W-1:0]                         cap_lane_q;
    logic [bytes_per_entry_g*data_width_g-1:0] entry_q;
    logic [INDEX_WIDTH-1:0]                    cnt_q;
    logic                                      out_valid_q;
    logic                                      busy_q;
    logic                                      done_q;

    // One process owns address issue, the capture pipeline one cycle behind it,
    // and the output handshake; ram_addr simply keeps counting between entries.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            ram_enable_q <= 1'b0;
            ram_addr_q   <= '0;
            lane_q       <= '0;
            cap_valid_q  <= 1'b0;
            cap_lane_q   <= '0;
            entry_q      <= '0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            // Read data appears one cycle after its enable; land it in its lane
            cap_valid_q <= ram_enable_q;
            cap_lane_q  <= lane_q;
            if (cap_valid_q) begin
                entry_q[int'(cap_lane_q)*data_width_g +: data_width_g] <= ram_q;
            end
            done_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q      <= ISSUE;
                        ram_enable_q <= 1'b1;
                        ram_addr_q   <= base_addr;
                        lane_q       <= '0;
                        cnt_q        <= '0;
                        busy_q       <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (lane_q == LAST_LANE) begin
                        ram_enable_q <= 1'b0;
                        state_q      <= DRAIN;
                    end else begin
                        lane_q     <= lane_q + 1'b1;
                        ram_addr_q <= ram_addr_q + 1'b1;
                    end
                end
                DRAIN: begin
`ifdef SPRITE_SKIP_EMPTY_EN
                    // Byte 0 is already captured here; an empty slot is dropped
                    if (entry_q[data_width_g-1:0] == '0) begin
                        if (cnt_q == LAST_ENTRY) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q        <= cnt_q + 1'b1;
                            state_q      <= ISSUE;
                            ram_enable_q <= 1'b1;
                            ram_addr_q   <= ram_addr_q + 1'b1;
                            lane_q       <= '0;
                        end
                    end else begin
                        state_q     <= PRESENT;
                        out_valid_q <= 1'b1;
                    end
`else
                    state_q     <= PRESENT;
                    out_valid_q <= 1'b1;
`endif
                end
                PRESENT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (cnt_q == LAST_ENTRY) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q        <= cnt_q + 1'b1;
                            state_q      <= ISSUE;
                            ram_enable_q <= 1'b1;
                            ram_addr_q   <= ram_addr_q + 1'b1;
                            lane_q       <= '0;
                        end
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ram_enable = ram_enable_q;
    assign ram_addr   = ram_addr_q;
    assign out_valid  = out_valid_q;
    assign out_data   = entry_q;
    assign out_index  = cnt_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_sprite_attr_reader.sv
// Testbench for sprite_attr_reader: randomized sprite RAM contents and ready
// patterns, checked against a table-walk model of the expected entries.
module tb_sprite_attr_reader;

    localparam int AW  = 11;
    localparam int DW  = 8;
    localparam int BPE = 4;
    localparam int NE  = 24;
`ifdef SPRITE_SKIP_EMPTY_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    logic              clock;
    logic              reset;
    logic              start;
    logic [AW-1:0]     base_addr;
    logic              ram_enable;
    logic [AW-1:0]     ram_addr;
    logic [DW-1:0]     ram_q;
    logic              out_valid;
    logic              out_ready;
    logic [BPE*DW-1:0] out_data;
    logic [4:0]        out_index;
    logic              busy;
    logic              done;
    logic [2:0]        state_dbg;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int xfer_cnt;
    logic [31:0] first_data;
    logic [7:0]  mem [0:2047];

    sprite_attr_reader dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .ram_enable (ram_enable),
        .ram_addr   (ram_addr),
        .ram_q      (ram_q),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_index  (out_index),
        .busy       (busy),
        .done       (done),
        .state_dbg  (state_dbg)
    );

    // Clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Sprite RAM read port: one-cycle registered read
    always @(posedge clock) begin
        if (ram_enable) ram_q <= mem[ram_addr];
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Run one full scan from base, checking addresses, entries, timing and done
    task automatic run_scan(input logic [AW-1:0] base, input int stall_idx,
                            input bit rand_ready, input bit mid_start);
        logic [31:0]   exp_q[$];
        logic [4:0]    idx_q[$];
        logic [AW-1:0] addr_q[$];
        logic [31:0]   ent;
        logic [AW-1:0] a;
        int n, last_xfer_n, last_en_n, prev_xfer_n, prev_idx, stall_left, done_cnt, exp_done_n;
        bit finished, chk_after, hold_pending, first_presented, done_prev;
        for (int i = 0; i < NE; i++) begin
            ent = '0;
            for (int k = 0; k < BPE; k++) begin
                a = AW'(int'(base) + i * BPE + k);
                addr_q.push_back(a);
                ent[k*DW +: DW] = mem[a];
            end
            if (!(SKIP_EN && ent[7:0] == 8'h00)) begin
                exp_q.push_back(ent);
                idx_q.push_back(5'(i));
            end
        end
        first_presented = (idx_q.size() > 0) && (idx_q[0] == 5'd0);
        n = 0; last_xfer_n = -1; last_en_n = -1; prev_xfer_n = -1; prev_idx = -1;
        stall_left = 10; done_cnt = 0; exp_done_n = 0;
        finished = 0; chk_after = 0; hold_pending = 0; done_prev = 0;
        xfer_cnt = 0;
        start = 1'b1;
        base_addr = base;
        out_ready = 1'b1;
        for (int t = 0; t < 1000 && !finished; t++) begin
            @(negedge clock);
            n++;
            start = mid_start && (n == 9);
            base_addr = start ? ~base : AW'($urandom);
            if (n == 1) begin
                total_cnt++;
                if (busy !== 1'b1) $display("FAIL busy_after_start: got %b want 1", busy);
                else pass_cnt++;
            end
            if (chk_after) begin
                chk_after = 0;
                total_cnt++;
                if (out_valid !== 1'b0) $display("FAIL valid_drop_after_xfer: got %b want 0", out_valid);
                else pass_cnt++;
                if (addr_q.size() > 0) begin
                    total_cnt++;
                    if (ram_enable !== 1'b1) $display("FAIL next_issue_after_xfer: got %b want 1", ram_enable);
                    else pass_cnt++;
                end
            end
            if (ram_enable === 1'b1) begin
                last_en_n = n;
                total_cnt++;
                if (addr_q.size() == 0) begin
                    $display("FAIL extra_read: got addr %h want no read", ram_addr);
                end else begin
                    if (ram_addr !== addr_q[0]) $display("FAIL read_addr: got %h want %h", ram_addr, addr_q[0]);
                    else pass_cnt++;
                    void'(addr_q.pop_front());
                end
                total_cnt++;
                if (out_valid !== 1'b0) $display("FAIL read_while_present: got out_valid %b want 0", out_valid);
                else pass_cnt++;
            end
            if (done_prev) begin
                total_cnt++;
                if ({busy, done} !== 2'b00) $display("FAIL end_idle: got busy,done %b want 00", {busy, done});
                else pass_cnt++;
                finished = 1;
            end else if (done === 1'b1) begin
                done_cnt++;
                done_prev = 1;
                exp_done_n = ((last_xfer_n > last_en_n + 1) ? last_xfer_n : last_en_n + 1) + 1;
                total_cnt++;
                if (n != exp_done_n) $display("FAIL done_cycle: got %0d want %0d", n, exp_done_n);
                else pass_cnt++;
                total_cnt++;
                if (exp_q.size() != 0) $display("FAIL done_early: got %0d pending want 0", exp_q.size());
                else pass_cnt++;
            end
            // Ready for the coming edge
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            else if (out_valid && int'(out_index) == stall_idx && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else out_ready = 1'b1;
            if (out_valid === 1'b1) begin
                if (!hold_pending) begin
                    if (prev_xfer_n < 0) begin
                        if (first_presented) begin
                            total_cnt++;
                            if (n != BPE + 2) $display("FAIL first_valid_cycle: got %0d want %0d", n, BPE + 2);
                            else pass_cnt++;
                        end
                    end else if (int'(out_index) == prev_idx + 1) begin
                        total_cnt++;
                        if (n - prev_xfer_n != BPE + 2)
                            $display("FAIL entry_spacing: got %0d want %0d", n - prev_xfer_n, BPE + 2);
                        else pass_cnt++;
                    end
                end
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_entry: got idx %0d data %h want none", out_index, out_data);
                end else if (out_data !== exp_q[0] || out_index !== idx_q[0]) begin
                    $display("FAIL entry: got idx %0d data %h want idx %0d data %h",
                             out_index, out_data, idx_q[0], exp_q[0]);
                end else pass_cnt++;
                if (out_ready) begin
                    if (xfer_cnt == 0) first_data = out_data;
                    xfer_cnt++;
                    if (exp_q.size() > 0) begin
                        void'(exp_q.pop_front());
                        void'(idx_q.pop_front());
                    end
                    prev_xfer_n = n;
                    last_xfer_n = n;
                    prev_idx = int'(out_index);
                    chk_after = 1;
                end
            end
            hold_pending = (out_valid === 1'b1) && !out_ready;
        end
        start = 1'b0;
        out_ready = 1'b1;
        total_cnt++;
        if (!finished) $display("FAIL scan_timeout: got no done within budget want done");
        else pass_cnt++;
        total_cnt++;
        if (done_cnt != 1) $display("FAIL done_count: got %0d want 1", done_cnt);
        else pass_cnt++;
        total_cnt++;
        if (addr_q.size() != 0 || exp_q.size() != 0)
            $display("FAIL scan_incomplete: got %0d reads %0d entries left want 0 0", addr_q.size(), exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        base_addr = '0;
        repeat (3) @(negedge clock);
        total_cnt++;
        if ({ram_enable, ram_addr, out_valid, out_data, out_index, busy, done} !== '0)
            $display("FAIL reset_outputs: got en %b addr %h v %b data %h idx %0d busy %b done %b want all 0",
                     ram_enable, ram_addr, out_valid, out_data, out_index, busy, done);
        else pass_cnt++;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        total_cnt++;
        if ({ram_enable, out_valid, busy, done} !== 4'b0000)
            $display("FAIL idle_after_reset: got %b want 0000", {ram_enable, out_valid, busy, done});
        else pass_cnt++;
    endtask

    task automatic test_single_scan();
        mem[11'h100] = 8'h11;
        mem[11'h101] = 8'h22;
        mem[11'h102] = 8'h33;
        mem[11'h103] = 8'h44;
        run_scan(11'h100, -1, 1'b0, 1'b0);
        total_cnt++;
        if (first_data !== 32'h44332211) $display("FAIL single_first_entry: got %h want 44332211", first_data);
        else pass_cnt++;
        total_cnt++;
        if (xfer_cnt != NE) $display("FAIL single_count: got %0d want %0d", xfer_cnt, NE);
        else pass_cnt++;
    endtask

    task automatic test_back_pressure();
        run_scan(AW'($urandom_range(0, 2047)), 3, 1'b0, 1'b0);
    endtask

    task automatic test_random_ready();
        run_scan(AW'($urandom_range(0, 2047)), -1, 1'b1, 1'b0);
    endtask

    task automatic test_wrap();
        run_scan(11'h7FE, -1, 1'b0, 1'b0);
    endtask

    task automatic test_mid_start();
        run_scan(11'h200, -1, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_scan(AW'($urandom_range(0, 2047)), -1, 1'b0, 1'b0);
        run_scan(AW'($urandom_range(0, 2047)), -1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid(input bit in_present);
        bit saw;
        out_ready = in_present ? 1'b0 : 1'b1;
        start = 1'b1;
        base_addr = AW'($urandom);
        @(negedge clock);
        start = 1'b0;
        if (in_present) begin
            for (int t = 0; t < 20 && out_valid !== 1'b1; t++) @(negedge clock);
            total_cnt++;
            if (out_valid !== 1'b1) $display("FAIL reach_present: got %b want 1", out_valid);
            else pass_cnt++;
        end else begin
            @(negedge clock);
        end
        reset = 1'b1;
        @(negedge clock);
        total_cnt++;
        if ({ram_enable, ram_addr, out_valid, out_data, out_index, busy, done} !== '0)
            $display("FAIL reset_mid_outputs: got en %b addr %h v %b data %h idx %0d busy %b done %b want all 0",
                     ram_enable, ram_addr, out_valid, out_data, out_index, busy, done);
        else pass_cnt++;
        reset = 1'b0;
        out_ready = 1'b1;
        saw = 0;
        repeat (8) begin
            @(negedge clock);
            if (done || busy || out_valid || ram_enable) saw = 1;
        end
        total_cnt++;
        if (saw) $display("FAIL reset_mid_quiet: got activity after reset want none");
        else pass_cnt++;
    endtask

    task automatic test_skip();
        mem[11'h300 + 4]  = 8'h00;
        mem[11'h300 + 92] = 8'h00;
        run_scan(11'h300, -1, 1'b0, 1'b0);
        total_cnt++;
        if (xfer_cnt != (SKIP_EN ? NE - 2 : NE))
            $display("FAIL skip_count: got %0d want %0d", xfer_cnt, SKIP_EN ? NE - 2 : NE);
        else pass_cnt++;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom_range(1, 255));
        test_reset();
        test_single_scan();
        test_back_pressure();
        test_random_ready();
        test_wrap();
        test_mid_start();
        test_reset_mid(1'b0);
        test_single_scan();
        test_reset_mid(1'b1);
        test_back_to_back();
        test_skip();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sprite_attr_reader.md
# sprite_attr_reader

Initiator that walks a block of sprite attribute RAM through the read-only port of a dual-port block RAM. The RAM has 1-cycle registered read latency. Each multi-byte sprite entry is assembled and handed downstream over a valid/ready handshake. Sits between the CPU-shared sprite RAM and the per-line sprite renderer, and is triggered once per line at horizontal blank.

## Interface
Parameters:
- addr_width_g, 11, RAM address width; must match the attached RAM.
- data_width_g, 8, RAM word width.
- bytes_per_entry_g, 4, RAM words per sprite entry (≥2).
- num_entries_g, 24, entries read per scan (≥1).

Ports:
- clock  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle scan request; ignored while busy.
- base_addr  in  addr_width_g  first RAM address of the table; sampled on accepted start.
- ram_enable  out  1  read strobe to RAM enable; wren is tied low externally.
- ram_addr  out  addr_width_g  RAM read address (registered).
- ram_q  in  data_width_g  RAM read data, valid the cycle after the enable/address cycle.
- out_valid  out  1  entry available.
- out_ready  in  1  downstream accepts.
- out_data  out  bytes_per_entry_g*data_width_g  assembled entry; byte 0 in the LSBs.
- out_index  out  5  entry number (0..num_entries_g-1) of out_data.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse at scan end.

## Operation
- FSM states:
  - IDLE: accepted start latches base_addr, clears the entry counter, and goes to ISSUE.
  - ISSUE: drives ram_enable for bytes_per_entry_g consecutive cycles, with ram_addr = base + entry*bytes_per_entry_g + k for k = 0..bytes_per_entry_g-1.
  - DRAIN: one cycle capturing the final byte.
  - PRESENT: holds out_valid until out_ready.
  - FIN: pulses done and returns to IDLE.
- Byte k returns on ram_q one cycle after its address and is written into lane k of the entry register. Capture is pipelined behind issue.
- On a transfer (out_valid & out_ready), the counter increments. If entries remain, go to ISSUE; otherwise go to FIN.
- Address arithmetic is modulo 2^addr_width_g; a table crossing the top of RAM wraps to 0.
- out_data and out_index are stable while out_valid is high and out_ready is low.
- start while busy has no effect; base_addr changes mid-scan have no effect.
- Reset in any state: return to IDLE immediately. No done pulse is issued and the partial entry is discarded.
- Reset values: ram_enable 0, ram_addr 0, out_valid 0, out_data 0, out_index 0, busy 0, done 0.

## Timing
- start high in cycle S: busy high from S+1; ram_enable high in S+1..S+bytes_per_entry_g; out_valid first high in cycle S+bytes_per_entry_g+2 (S+6 at default).
- Transfer at the edge ending cycle T: out_valid low in T+1. The next entry's ram_enable is high in T+1..T+bytes_per_entry_g, and out_valid is high again in T+bytes_per_entry_g+2.
- Final transfer at cycle T: done high in T+1 only; busy low from T+2. A start in T+2 is accepted.
- out_ready held high yields throughput of one entry per bytes_per_entry_g+2 cycles.
- ram_enable is never high in PRESENT, so there is no RAM read while stalled.

## Configuration
- SPRITE_SKIP_EMPTY_EN defined: an entry whose byte 0 equals 0 is discarded after DRAIN. It is never presented; the counter advances and ISSUE of the next entry starts in the following cycle. out_index still reports the true table index. If the final entry is empty, FIN follows DRAIN directly.
- Undefined: every entry is presented regardless of content.

## Structure
- Shared package bj_video_pkg: FSM state enum (IDLE, ISSUE, DRAIN, PRESENT, FIN) and the default entry-geometry constants used by the renderer.
- No sub-module: the address generator, byte-lane capture and FSM fit one module. The RAM instance lives in the parent.

## Test plan
- Single scan, out_ready tied high, base_addr 0x100, RAM[0x100..0x103] = 11,22,33,44: out_data 0x44332211 with out_index 0 in cycle S+6. 24 entries are delivered and done pulses once.
- Back-pressure: out_ready low for 10 cycles on entry 3: out_valid and out_data are held constant, ram_enable stays 0, and entry 4 reads begin the cycle after the transfer.
- Wrap: base_addr 0x7FE with addr_width_g 11: entry 0 reads 0x7FE, 0x7FF, 0x000, 0x001.
- start pulsed mid-scan with a different base_addr: no effect; the scan completes on the original base and done pulses once.
- Reset asserted in ISSUE and in PRESENT: next cycle all outputs are 0, no done pulse; a new start then works normally.
- With SPRITE_SKIP_EMPTY_EN, entries 1 and 23 have byte 0 = 0: 22 transfers with out_index skipping 1 and 23; done follows entry 23's DRAIN by one cycle.
